// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared definitions for the write-back stage and its CP0 block.
// CP0 addresses are {rd[4:0], sel[2:0]}. The optional timer is enabled by the
// CP0_TIMER_EN macro (see wb_stage_cp0_regfile.sv).
package wb_stage_pkg;

    localparam int MS_TO_WS_BUS_WD = 125;
    localparam int WS_FWD_BUS_WD   = 42;

    // CP0 register addresses as {rd, sel}
    localparam logic [7:0] CR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CR_EPC      = {5'd14, 3'd0};

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;

    // Memory-to-writeback bus, MSB first
    typedef struct packed {
        logic        tlbwi;
        logic        tlbr;
        logic [31:0] badvaddr;
        logic        eret;
        logic        mtc0;
        logic        mfc0;
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic        bd;
        logic        ex;
        logic [4:0]  excode;
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_bus_t;

    // Address-error exceptions are the only ones that record BadVAddr
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-stage to write-back-stage handshake.
// A transfer happens on a rising clk edge where ms_to_ws_valid && ws_allowin;
// ms_to_ws_bus must be stable whenever ms_to_ws_valid is high, and the
// write-back stage never stalls, so ws_allowin is held at 1.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       ws_allowin;

    modport master (output ms_to_ws_valid, output ms_to_ws_bus, input ws_allowin);
    modport slave  (input ms_to_ws_valid, input ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_stage_cp0_regfile.sv
// cp0_regfile: CP0 Status/Cause/EPC/BadVAddr/Count/Compare, read mux and
// interrupt-pending logic. Defining CP0_TIMER_EN adds the Count/Compare timer
// (Count ticks every second cycle, TI raises IP7); otherwise Count and
// Compare are plain registers and TI is tied low.
module cp0_regfile
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex,
    input  logic        eret,
    input  logic        mtc0,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [4:0]  excode,
    input  logic [31:0] badvaddr,
    input  logic [5:0]  ext_int,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic        int_pending
);

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exccode;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [7:0]  cause_ip;

    logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;
    assign wr_status  = mtc0 && (addr == CR_STATUS);
    assign wr_cause   = mtc0 && (addr == CR_CAUSE);
    assign wr_epc     = mtc0 && (addr == CR_EPC);
    assign wr_count   = mtc0 && (addr == CR_COUNT);
    assign wr_compare = mtc0 && (addr == CR_COMPARE);

    // IP7 also carries the timer interrupt
    assign cause_ip = {cause_ip_hw[5] | cause_ti, cause_ip_hw[4:0], cause_ip_sw};

    // Status: software writes IM/EXL/IE; exception entry sets EXL, ERET clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            status_im  <= 8'h00;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else begin
            if (wr_status) begin
                status_im  <= wdata[15:8];
                status_exl <= wdata[1];
                status_ie  <= wdata[0];
            end
            if (ex)
                status_exl <= 1'b1;
            else if (eret)
                status_exl <= 1'b0;
        end
    end

    // Cause: hardware lines sampled every cycle, IP[1:0] software-writable,
    // BD only recorded when not already inside an exception handler
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_bd      <= 1'b0;
            cause_ip_hw   <= 6'd0;
            cause_ip_sw   <= 2'd0;
            cause_exccode <= 5'd0;
        end else begin
            cause_ip_hw <= ext_int;
            if (wr_cause)
                cause_ip_sw <= wdata[9:8];
            if (ex) begin
                if (!status_exl)
                    cause_bd <= bd;
                cause_exccode <= excode;
            end
        end
    end

    // EPC and BadVAddr; BadVAddr ignores mtc0
    always_ff @(posedge clk) begin
        if (reset) begin
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            if (ex && !status_exl)
                epc_q <= bd ? (pc - 32'd4) : pc;
            else if (wr_epc)
                epc_q <= wdata;
            if (ex && is_addr_exc(excode))
                badvaddr_q <= badvaddr;
        end
    end

`ifdef CP0_TIMER_EN
    logic        tick_q;
    logic [31:0] count_inc;
    assign count_inc = count_q + 32'd1;

    // Timer: Count advances on every other cycle; a software write wins
    // over the tick, and a Compare write wins over a match
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            cause_ti  <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            if (wr_count)
                count_q <= wdata;
            else if (tick_q)
                count_q <= count_inc;
            if (wr_compare) begin
                compare_q <= wdata;
                cause_ti  <= 1'b0;
            end else if (tick_q && (count_inc == compare_q)) begin
                cause_ti <= 1'b1;
            end
        end
    end
`else
    assign cause_ti = 1'b0;

    // Count/Compare as plain software registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
        end else begin
            if (wr_count)
                count_q <= wdata;
            if (wr_compare)
                compare_q <= wdata;
        end
    end
`endif

    // Read mux; unmapped addresses return 0, BEV reads as 1
    always_comb begin
        rdata = 32'd0;
        case (addr)
            CR_STATUS:   rdata = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
            CR_CAUSE:    rdata = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exccode, 2'd0};
            CR_EPC:      rdata = epc_q;
            CR_BADVADDR: rdata = badvaddr_q;
            CR_COUNT:    rdata = count_q;
            CR_COMPARE:  rdata = compare_q;
            default:     rdata = 32'd0;
        endcase
    end

    assign epc         = epc_q;
    assign int_pending = status_ie && !status_exl && |(cause_ip & status_im);

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Retires one instruction per cycle, writes the
// register file, commits CP0 updates and raises flush/redirect on exception,
// interrupt or ERET. The CP0 timer is built in when CP0_TIMER_EN is defined.
module wb_stage
    import wb_stage_pkg::ms_bus_t, wb_stage_pkg::WS_FWD_BUS_WD, wb_stage_pkg::EXC_INT;
#(
    parameter logic [31:0] EXC_VECTOR      = 32'hBFC0_0380,
    parameter int          MS_TO_WS_BUS_WD = 125
) (
    input  logic                     clk,
    input  logic                     reset,
    wb_stage_if.slave                ms_if,
    input  logic [5:0]               ext_int,
    output logic [3:0]               rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic [WS_FWD_BUS_WD-1:0] ws_fwd_bus,
    output logic                     flush,
    output logic [31:0]              flush_pc,
    output logic                     tlbwi_req,
    output logic                     tlbr_req,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_wen,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata
);

    logic                       ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] bus_q;
    ms_bus_t                    bus;
    logic                       int_pending;
    logic                       int_take;
    logic                       ws_ex;
    logic                       ws_eret;
    logic                       ws_mtc0;
    logic [4:0]                 ws_excode;
    logic [31:0]                cp0_rdata;
    logic [31:0]                cp0_epc;

    assign bus = ms_bus_t'(bus_q);

    // Never stalls
    assign ms_if.ws_allowin = 1'b1;

    // Valid bit: a flush kills whatever the memory stage offers this cycle
    always_ff @(posedge clk) begin
        if (reset)
            ws_valid <= 1'b0;
        else if (flush)
            ws_valid <= 1'b0;
        else
            ws_valid <= ms_if.ms_to_ws_valid;
    end

    // Stage payload register
    always_ff @(posedge clk) begin
        if (reset)
            bus_q <= '0;
        else if (ms_if.ms_to_ws_valid && ms_if.ws_allowin)
            bus_q <= ms_if.ms_to_ws_bus;
    end

    assign int_take  = ws_valid && int_pending;
    assign ws_ex     = ws_valid && (bus.ex || int_take);
    assign ws_eret   = ws_valid && bus.eret && !ws_ex;
    assign ws_mtc0   = ws_valid && bus.mtc0 && !ws_ex;
    assign ws_excode = bus.ex ? bus.excode : EXC_INT;

    cp0_regfile u_cp0 (
        .clk         (clk),
        .reset       (reset),
        .ex          (ws_ex),
        .eret        (ws_eret),
        .mtc0        (ws_mtc0),
        .addr        ({bus.rd, bus.sel}),
        .wdata       (bus.result),
        .pc          (bus.pc),
        .bd          (bus.bd),
        .excode      (ws_excode),
        .badvaddr    (bus.badvaddr),
        .ext_int     (ext_int),
        .rdata       (cp0_rdata),
        .epc         (cp0_epc),
        .int_pending (int_pending)
    );

    assign flush    = ws_valid && (ws_ex || bus.eret);
    assign flush_pc = ws_ex ? EXC_VECTOR : cp0_epc;

    assign rf_we     = (ws_valid && !ws_ex) ? bus.rf_we : 4'd0;
    assign rf_waddr  = bus.dest;
    assign rf_wdata  = bus.mfc0 ? cp0_rdata : bus.result;
    assign tlbwi_req = ws_valid && !ws_ex && bus.tlbwi;
    assign tlbr_req  = ws_valid && !ws_ex && bus.tlbr;

    assign ws_fwd_bus = {ws_valid, rf_we, rf_waddr, rf_wdata};

    assign debug_wb_pc       = bus.pc;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed instruction stream into wb_stage; every retiring
// instruction is compared against a hand-computed expectation queue.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int EW = 108;
  localparam logic [31:0] EXCV = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  ext_int;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [WS_FWD_BUS_WD-1:0] ws_fwd_bus;
  logic        flush;
  logic [31:0] flush_pc;
  logic        tlbwi_req;
  logic        tlbr_req;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  wb_stage_if ms_if ();

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_if             (ms_if),
    .ext_int           (ext_int),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_bus        (ws_fwd_bus),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .tlbwi_req         (tlbwi_req),
    .tlbr_req          (tlbr_req),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // expected record: {pc, rf_we, waddr, wdata, flush, flush_pc, tlbwi, tlbr}
  function automatic logic [EW-1:0] ev(input logic [31:0] pc, input logic [3:0] we,
                                       input logic [4:0] wa, input logic [31:0] wd,
                                       input logic fl, input logic [31:0] fpc,
                                       input logic twi, input logic tr);
    return {pc, we, wa, wd, fl, fpc, twi, tr};
  endfunction

  function automatic logic [EW-1:0] act_main();
    return {debug_wb_pc, rf_we, rf_waddr, rf_wdata, flush, flush_pc, tlbwi_req, tlbr_req};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // instruction builders
  function automatic ms_bus_t alu(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res);
    ms_bus_t b;
    b = '0;
    b.pc = pc;
    b.dest = dest;
    b.result = res;
    b.rf_we = 4'hF;
    return b;
  endfunction

  function automatic ms_bus_t mtc0_i(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val);
    ms_bus_t b;
    b = '0;
    b.pc = pc;
    b.mtc0 = 1'b1;
    b.rd = rd;
    b.result = val;
    return b;
  endfunction

  function automatic ms_bus_t mfc0_i(input logic [31:0] pc, input logic [4:0] rd, input logic [2:0] sel,
                                     input logic [4:0] dest);
    ms_bus_t b;
    b = '0;
    b.pc = pc;
    b.mfc0 = 1'b1;
    b.rd = rd;
    b.sel = sel;
    b.dest = dest;
    b.rf_we = 4'hF;
    b.result = 32'hFFFF_FFFF;
    return b;
  endfunction

  // driver tasks
  task automatic issue(input ms_bus_t b, input logic [EW-1:0] e, input bit has_exp);
    ms_if.ms_to_ws_valid = 1'b1;
    ms_if.ms_to_ws_bus = b;
    if (has_exp) exp_q.push_back(e);
    @(posedge clk);
    #1;
    ms_if.ms_to_ws_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mfc0 with expected read value; flush_pc equals the current EPC
  task automatic rd_cp0(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val,
                        input logic [31:0] epc);
    issue(mfc0_i(pc, rd, 3'd0, 5'd2), ev(pc, 4'hF, 5'd2, val, 1'b0, epc, 1'b0, 1'b0), 1'b1);
  endtask

  task automatic wr_cp0(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val,
                        input logic [31:0] epc);
    issue(mtc0_i(pc, rd, val), ev(pc, 4'h0, 5'd0, val, 1'b0, epc, 1'b0, 1'b0), 1'b1);
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && ws_fwd_bus[41]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_retire act_pc=%h exp=none", debug_wb_pc);
        end else begin
          e = exp_q.pop_front();
          check("retire", act_main(), e);
          check("fwd_debug",
                {26'd0, ws_fwd_bus[40:0], debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata},
                {26'd0, e[75:35], e[75:35]});
        end
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    checks++;
    failures++;
    $display("FAIL timeout act=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // stimulus
  initial begin
    ms_bus_t b;
    ext_int = 6'd0;
    ms_if.ms_to_ws_valid = 1'b0;
    ms_if.ms_to_ws_bus = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", act_main(), '0);
    check("reset_fwd", {66'd0, ws_fwd_bus}, '0);
    check("allowin", {107'd0, ms_if.ws_allowin}, {107'd0, 1'b1});
    reset = 1'b0;
    idle(1);

    // back-to-back ALU ops and a partial byte-enable write
    issue(alu(32'hBFC0_0000, 5'd5, 32'h1234), ev(32'hBFC0_0000, 4'hF, 5'd5, 32'h1234, 1'b0, 32'd0, 1'b0, 1'b0), 1'b1);
    issue(alu(32'hBFC0_0004, 5'd5, 32'h1234), ev(32'hBFC0_0004, 4'hF, 5'd5, 32'h1234, 1'b0, 32'd0, 1'b0, 1'b0), 1'b1);
    issue(alu(32'hBFC0_0008, 5'd5, 32'h1234), ev(32'hBFC0_0008, 4'hF, 5'd5, 32'h1234, 1'b0, 32'd0, 1'b0, 1'b0), 1'b1);
    b = alu(32'hBFC0_000C, 5'd6, 32'hA5A5_0001);
    b.rf_we = 4'b0011;
    issue(b, ev(32'hBFC0_000C, 4'b0011, 5'd6, 32'hA5A5_0001, 1'b0, 32'd0, 1'b0, 1'b0), 1'b1);

    // mtc0 EPC then immediate mfc0 EPC
    wr_cp0(32'hBFC0_0010, 5'd14, 32'hDEAD_BEE0, 32'd0);
    rd_cp0(32'hBFC0_0014, 5'd14, 32'hDEAD_BEE0, 32'hDEAD_BEE0);

    // TLB strobes
    b = '0; b.pc = 32'hBFC0_0018; b.tlbwi = 1'b1;
    issue(b, ev(32'hBFC0_0018, 4'h0, 5'd0, 32'd0, 1'b0, 32'hDEAD_BEE0, 1'b1, 1'b0), 1'b1);
    b = '0; b.pc = 32'hBFC0_001C; b.tlbr = 1'b1;
    issue(b, ev(32'hBFC0_001C, 4'h0, 5'd0, 32'd0, 1'b0, 32'hDEAD_BEE0, 1'b0, 1'b1), 1'b1);

    // AdEL in a delay slot; the following instruction is killed
    b = alu(32'h8000_0010, 5'd9, 32'h55);
    b.ex = 1'b1; b.excode = EXC_ADEL; b.bd = 1'b1; b.badvaddr = 32'h3;
    issue(b, ev(32'h8000_0010, 4'h0, 5'd9, 32'h55, 1'b1, EXCV, 1'b0, 1'b0), 1'b1);
    issue(alu(32'h8000_0014, 5'd7, 32'h99), '0, 1'b0);
    rd_cp0(32'h0000_0300, 5'd12, 32'h0040_0002, 32'h8000_000C);
    rd_cp0(32'h0000_0304, 5'd13, 32'h8000_0010, 32'h8000_000C);
    rd_cp0(32'h0000_0308, 5'd14, 32'h8000_000C, 32'h8000_000C);
    rd_cp0(32'h0000_030C, 5'd8,  32'h0000_0003, 32'h8000_000C);

    // BadVAddr is read-only
    wr_cp0(32'h0000_0310, 5'd8, 32'h0000_FFFF, 32'h8000_000C);
    rd_cp0(32'h0000_0314, 5'd8, 32'h0000_0003, 32'h8000_000C);

    // nested exception with EXL=1: EPC, BD and BadVAddr hold, ExcCode updates
    b = '0; b.pc = 32'h0000_0320; b.ex = 1'b1; b.excode = EXC_SYS; b.badvaddr = 32'h777;
    issue(b, ev(32'h0000_0320, 4'h0, 5'd0, 32'd0, 1'b1, EXCV, 1'b0, 1'b0), 1'b1);
    issue(alu(32'h0000_0324, 5'd7, 32'h99), '0, 1'b0);
    rd_cp0(32'h0000_0328, 5'd13, 32'h8000_0020, 32'h8000_000C);
    rd_cp0(32'h0000_032C, 5'd14, 32'h8000_000C, 32'h8000_000C);
    rd_cp0(32'h0000_0330, 5'd8,  32'h0000_0003, 32'h8000_000C);

    // ERET redirects to EPC and clears EXL
    b = '0; b.pc = 32'h0000_0334; b.eret = 1'b1;
    issue(b, ev(32'h0000_0334, 4'h0, 5'd0, 32'd0, 1'b1, 32'h8000_000C, 1'b0, 1'b0), 1'b1);
    issue(alu(32'h0000_0338, 5'd7, 32'h99), '0, 1'b0);
    rd_cp0(32'h8000_000C, 5'd12, 32'h0040_0000, 32'h8000_000C);

    // unmapped reads return 0
    issue(mfc0_i(32'h8000_0020, 5'd0, 3'd0, 5'd4), ev(32'h8000_0020, 4'hF, 5'd4, 32'd0, 1'b0, 32'h8000_000C, 1'b0, 1'b0), 1'b1);
    issue(mfc0_i(32'h8000_0024, 5'd12, 3'd1, 5'd4), ev(32'h8000_0024, 4'hF, 5'd4, 32'd0, 1'b0, 32'h8000_000C, 1'b0, 1'b0), 1'b1);

    // hardware interrupt on ext_int[0] through IM2
    wr_cp0(32'h0000_0400, 5'd12, 32'h0000_0401, 32'h8000_000C);
    rd_cp0(32'h0000_0404, 5'd12, 32'h0040_0401, 32'h8000_000C);
    ext_int = 6'b000001;
    idle(2);
    issue(alu(32'h8000_0200, 5'd3, 32'd77), ev(32'h8000_0200, 4'h0, 5'd3, 32'd77, 1'b1, EXCV, 1'b0, 1'b0), 1'b1);
    issue(alu(32'h8000_0204, 5'd7, 32'h99), '0, 1'b0);
    rd_cp0(32'h0000_0408, 5'd13, 32'h0000_0400, 32'h8000_0200);
    rd_cp0(32'h0000_040C, 5'd14, 32'h8000_0200, 32'h8000_0200);
    rd_cp0(32'h0000_0410, 5'd12, 32'h0040_0403, 32'h8000_0200);
    ext_int = 6'd0;
    idle(2);
    b = '0; b.pc = 32'h0000_0414; b.eret = 1'b1;
    issue(b, ev(32'h0000_0414, 4'h0, 5'd0, 32'd0, 1'b1, 32'h8000_0200, 1'b0, 1'b0), 1'b1);
    issue(alu(32'h0000_0418, 5'd7, 32'h99), '0, 1'b0);
    wr_cp0(32'h0000_041C, 5'd12, 32'h0000_0000, 32'h8000_0200);

    // Cause: only IP[1:0] writable
    wr_cp0(32'h0000_0420, 5'd13, 32'hFFFF_FFFF, 32'h8000_0200);
    rd_cp0(32'h0000_0424, 5'd13, 32'h0000_0300, 32'h8000_0200);
    wr_cp0(32'h0000_0428, 5'd13, 32'h0000_0000, 32'h8000_0200);

`ifdef CP0_TIMER_EN
    // timer: Compare=10, Count=0, IM7+IE -> interrupt once TI rises
    wr_cp0(32'h0000_0500, 5'd11, 32'd10, 32'h8000_0200);
    wr_cp0(32'h0000_0504, 5'd9,  32'd0,  32'h8000_0200);
    wr_cp0(32'h0000_0508, 5'd12, 32'h0000_8001, 32'h8000_0200);
    idle(30);
    issue(alu(32'h0000_0600, 5'd3, 32'd5), ev(32'h0000_0600, 4'h0, 5'd3, 32'd5, 1'b1, EXCV, 1'b0, 1'b0), 1'b1);
    issue(alu(32'h0000_0604, 5'd7, 32'h99), '0, 1'b0);
    rd_cp0(32'h0000_0608, 5'd13, 32'h4000_8000, 32'h0000_0600);
    wr_cp0(32'h0000_060C, 5'd11, 32'd1000, 32'h0000_0600);
    rd_cp0(32'h0000_0610, 5'd13, 32'h0000_0000, 32'h0000_0600);
    b = '0; b.pc = 32'h0000_0614; b.eret = 1'b1;
    issue(b, ev(32'h0000_0614, 4'h0, 5'd0, 32'd0, 1'b1, 32'h0000_0600, 1'b0, 1'b0), 1'b1);
    issue(alu(32'h0000_0618, 5'd7, 32'h99), '0, 1'b0);
    wr_cp0(32'h0000_061C, 5'd12, 32'h0000_0000, 32'h0000_0600);
`else
    // Count/Compare as plain registers
    wr_cp0(32'h0000_0500, 5'd9,  32'h0000_1234, 32'h8000_0200);
    rd_cp0(32'h0000_0504, 5'd9,  32'h0000_1234, 32'h8000_0200);
    wr_cp0(32'h0000_0508, 5'd11, 32'h0000_55AA, 32'h8000_0200);
    rd_cp0(32'h0000_050C, 5'd11, 32'h0000_55AA, 32'h8000_0200);
    rd_cp0(32'h0000_0510, 5'd13, 32'h0000_0000, 32'h8000_0200);
`endif

    idle(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
